// File: rtl/snd_clkgen_frac.sv
// snd_clkgen_frac: fractional-accumulator audio clock generator (MCLK/BCLK/LRCK).
// Ports: CLK, RST_N, ENABLE, RATE_VLD/RATE_INC/RATE_RDY, SND_MCLK/BCLK/LRCK,
//        MCLK_RISE, FRAME_START; FRAME_CNT only with SND_CLKGEN_FRAME_CNT_EN.
module snd_clkgen_frac #(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INC_DEFAULT = 32'h9D49_5183,
  parameter int               BCLK_DIV    = 4,
  parameter int               LR_BCLKS    = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             RATE_VLD,
  input  logic [ACC_W-1:0] RATE_INC,
  output logic             RATE_RDY,
  output logic             SND_MCLK,
  output logic             SND_BCLK,
  output logic             SND_LRCK,
  output logic             MCLK_RISE,
`ifdef SND_CLKGEN_FRAME_CNT_EN
  output logic [15:0]      FRAME_CNT,
`endif
  output logic             FRAME_START
);

  localparam int BH = BCLK_DIV / 2;
  localparam int LH = LR_BCLKS / 2;
  localparam int BW = (BH > 1) ? $clog2(BH) : 1;
  localparam int LW = (LH > 1) ? $clog2(LH) : 1;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_PEND,
    RS_DONE
  } rate_st_t;

  rate_st_t st_q;
  rate_st_t st_d;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend;
  logic [ACC_W:0]   sum;
  logic [BW-1:0]    bcnt;
  logic [LW-1:0]    lcnt;

  logic tick;
  logic mfall;
  logic bwrap;
  logic bfall;
  logic lwrap;
  logic bound;
  logic frozen;
  logic accept;
  logic apply;

  assign sum    = {1'b0, acc} + {1'b0, inc};
  assign tick   = ENABLE & sum[ACC_W];
  assign mfall  = tick & SND_MCLK;
  assign bwrap  = (bcnt == BW'(BH - 1));
  assign bfall  = mfall & bwrap & SND_BCLK;
  assign lwrap  = (lcnt == LW'(LH - 1));
  // LRCK 1->0 is the frame boundary; every divider is at phase 0 here.
  assign bound  = bfall & lwrap & SND_LRCK;
  // With inc = 0 no boundary ever arrives, so a pending rate must not wait.
  assign frozen = (inc == '0);

  always_comb begin
    st_d     = st_q;
    accept   = 1'b0;
    apply    = 1'b0;
    RATE_RDY = 1'b0;
    unique case (st_q)
      RS_IDLE: begin
        RATE_RDY = 1'b1;
        if (RATE_VLD) begin
          accept = 1'b1;
          st_d   = RS_PEND;
        end
      end
      RS_PEND: begin
        if (!ENABLE || frozen || bound) begin
          apply = 1'b1;
          st_d  = RS_DONE;
        end
      end
      RS_DONE: begin
        st_d = RS_IDLE;
      end
      default: begin
        st_d = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q <= RS_IDLE;
      pend <= '0;
      inc  <= INC_DEFAULT;
    end else begin
      st_q <= st_d;
      if (accept) begin
        pend <= RATE_INC;
      end
      if (apply) begin
        inc <= pend;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc       <= '0;
      SND_MCLK  <= 1'b0;
      MCLK_RISE <= 1'b0;
    end else if (!ENABLE) begin
      acc       <= '0;
      SND_MCLK  <= 1'b0;
      MCLK_RISE <= 1'b0;
    end else begin
      // A new rate starts from phase 0; the carry of this edge still counts.
      acc       <= apply ? '0 : sum[ACC_W-1:0];
      SND_MCLK  <= SND_MCLK ^ tick;
      MCLK_RISE <= tick & ~SND_MCLK;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bcnt     <= '0;
      SND_BCLK <= 1'b0;
    end else if (!ENABLE) begin
      bcnt     <= '0;
      SND_BCLK <= 1'b0;
    end else if (mfall) begin
      if (bwrap) begin
        bcnt     <= '0;
        SND_BCLK <= ~SND_BCLK;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lcnt        <= '0;
      SND_LRCK    <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (!ENABLE) begin
      lcnt        <= '0;
      SND_LRCK    <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= bound;
      if (bfall) begin
        if (lwrap) begin
          lcnt     <= '0;
          SND_LRCK <= ~SND_LRCK;
        end else begin
          lcnt <= lcnt + LW'(1);
        end
      end
    end
  end

`ifdef SND_CLKGEN_FRAME_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FRAME_CNT <= '0;
    end else if (!ENABLE) begin
      FRAME_CNT <= '0;
    end else if (bound) begin
      FRAME_CNT <= FRAME_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snd_clkgen_frac.sv
// tb_snd_clkgen_frac: randomized and directed checks of snd_clkgen_frac
// against a tick-count reference model.
module tb_snd_clkgen_frac;

  localparam int W  = 8;
  localparam int BD = 4;
  localparam int LB = 4;
  localparam int P  = 2 * BD * LB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rate_vld;
  logic [7:0] rate_inc;
  logic       rate_rdy;
  logic       mclk;
  logic       bclk;
  logic       lrck;
  logic       mrise;
  logic       fstart;
`ifdef SND_CLKGEN_FRAME_CNT_EN
  logic [15:0] fcnt;
`endif

  snd_clkgen_frac #(
    .ACC_W      (W),
    .INC_DEFAULT(8'h80),
    .BCLK_DIV   (BD),
    .LR_BCLKS   (LB)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .RATE_VLD   (rate_vld),
    .RATE_INC   (rate_inc),
    .RATE_RDY   (rate_rdy),
    .SND_MCLK   (mclk),
    .SND_BCLK   (bclk),
    .SND_LRCK   (lrck),
    .MCLK_RISE  (mrise),
`ifdef SND_CLKGEN_FRAME_CNT_EN
    .FRAME_CNT  (fcnt),
`endif
    .FRAME_START(fstart)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Model: total tick count k = kb + floor(t * inc / 2^W); every clock
  // level and pulse follows from k by plain division.
  longint kb, t, k, kprev;
  int     minc, mpend, mfc;
  bit     mpvld, mrdy, e_rise, e_fs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kb = 0; t = 0; k = 0; kprev = 0;
    minc = 8'h80; mpend = 0; mpvld = 0; mrdy = 1;
    mfc = 0; e_rise = 0; e_fs = 0;
  endtask

  task automatic model_edge(input bit en, input bit vld, input int rinc);
    bit take, old_pv, app;
    take   = vld && mrdy;
    old_pv = mpvld;
    if (en) begin
      t++;
      k = kb + ((t * minc) >> W);
    end else begin
      t = 0; kb = 0; k = 0;
    end
    e_rise = en && (k != kprev) && (k % 2 == 1);
    e_fs   = en && ((k / P) != (kprev / P));
    if (!en) mfc = 0;
    else if (e_fs) mfc = (mfc + 1) % 65536;
    app = mpvld && (!en || minc == 0 || e_fs);
    if (app) begin
      kb = k; t = 0; minc = mpend; mpvld = 0;
    end
    if (take) begin
      mpend = rinc; mpvld = 1; mrdy = 0;
    end else if (!mrdy && !old_pv) begin
      mrdy = 1;
    end
    kprev = k;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "/mclk"},  32'(mclk),     32'(k % 2));
    chk({ph, "/bclk"},  32'(bclk),     32'((k / BD) % 2));
    chk({ph, "/lrck"},  32'(lrck),     32'((k / (BD * LB)) % 2));
    chk({ph, "/mrise"}, 32'(mrise),    32'(e_rise));
    chk({ph, "/fstart"},32'(fstart),   32'(e_fs));
    chk({ph, "/rdy"},   32'(rate_rdy), 32'(mrdy));
`ifdef SND_CLKGEN_FRAME_CNT_EN
    chk({ph, "/fcnt"},  32'(fcnt),     32'(mfc));
`endif
  endtask

  task automatic step(input string ph, input bit en, input bit vld,
                      input int rinc);
    enable   = en;
    rate_vld = vld;
    rate_inc = rinc[7:0];
    @(posedge clk);
    model_edge(en, vld, rinc);
    #1;
    check_all(ph);
  endtask

  initial begin
    int sel, r;
    bit en, vld;
    rst_n = 1'b0; enable = 1'b1; rate_vld = 1'b0; rate_inc = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst_n = 1'b1;

    repeat (200) step("basic", 1, 0, 0);

    step("rate_offer", 1, 1, 8'h40);
    repeat (400) step("rate_run", 1, 0, 0);

    step("zero_offer", 1, 1, 8'h00);
    repeat (300) step("zero_run", 1, 0, 0);
    step("unfreeze", 1, 1, 8'h80);
    repeat (200) step("unfrozen", 1, 0, 0);

    repeat (5) step("stop", 0, 0, 0);
    repeat (200) step("restart", 1, 0, 0);

    step("stop_offer", 1, 1, 8'hC0);
    repeat (3) step("stop_pend", 0, 0, 0);
    repeat (150) step("stop_apply", 1, 0, 0);

    for (int i = 0; i < 20000; i++) begin
      en  = ($urandom_range(0, 399) != 0);
      vld = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 15);
      if (sel == 0) r = 0;
      else if (sel == 1) r = 128;
      else r = $urandom_range(16, 255);
      step("rand", en, vld, r);
    end

    for (int i = 0; i < 5000 && !mrdy; i++) step("pre_rst", 1, 0, 0);
    step("pre_rst_offer", 1, 1, 8'h20);
    repeat (7) step("pre_rst_run", 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #3 rst_n = 1'b1;
    repeat (200) step("post_rst", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
